// File: rtl/branch_pc_unit.sv
// Fetch PC register plus D-stage branch/jump resolver with perf counters and sticky misaligned-JR flag.
// Optional branch-likely ops (BEQL/BNEL, annulling the delay slot when not taken) under BRANCH_LIKELY_EN.
module branch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             d_valid,
  input  logic [31:0]      d_pc,
  input  logic [3:0]       br_op,
  input  logic [15:0]      imm16,
  input  logic [25:0]      index26,
  input  logic [31:0]      jr_target,
  input  logic [1:0]       cmp_reg,
  input  logic [1:0]       cmp_zero,
  output logic [31:0]      pc_f,
  output logic [31:0]      npc,
  output logic             taken,
  output logic [31:0]      link_pc,
  output logic             flush_d,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] taken_cnt,
  output logic             misalign_err
);
  localparam logic [3:0] OP_BEQ  = 4'd1;
  localparam logic [3:0] OP_BNE  = 4'd2;
  localparam logic [3:0] OP_BLEZ = 4'd3;
  localparam logic [3:0] OP_BGTZ = 4'd4;
  localparam logic [3:0] OP_BLTZ = 4'd5;
  localparam logic [3:0] OP_BGEZ = 4'd6;
  localparam logic [3:0] OP_J    = 4'd7;
  localparam logic [3:0] OP_JAL  = 4'd8;
  localparam logic [3:0] OP_JR   = 4'd9;
  localparam logic [3:0] OP_JALR = 4'd10;
`ifdef BRANCH_LIKELY_EN
  localparam logic [3:0] OP_BEQL = 4'd11;
  localparam logic [3:0] OP_BNEL = 4'd12;
  logic likely;
`endif

  logic [31:0] seq_pc, br_tgt, j_tgt, jr_tgt, target;
  logic        is_br, cond, is_jr, resolve;
  logic        r_eq, z_eq, z_gt, z_lt;

  // Code 11 folds into "less": only the two low codes are distinct.
  assign r_eq = (cmp_reg == 2'b00);
  assign z_eq = (cmp_zero == 2'b00);
  assign z_gt = (cmp_zero == 2'b01);
  assign z_lt = cmp_zero[1];

  assign seq_pc  = d_pc + 32'd4;
  assign br_tgt  = seq_pc + {{14{imm16[15]}}, imm16, 2'b00};
  assign j_tgt   = {seq_pc[31:28], index26, 2'b00};
  assign jr_tgt  = {jr_target[31:2], 2'b00};
  assign link_pc = d_pc + 32'd8;
  assign resolve = d_valid & ~stall;

  always_comb begin
    is_br  = 1'b1;
    cond   = 1'b0;
    is_jr  = 1'b0;
    target = br_tgt;
`ifdef BRANCH_LIKELY_EN
    likely = 1'b0;
`endif
    case (br_op)
      OP_BEQ:  cond = r_eq;
      OP_BNE:  cond = ~r_eq;
      OP_BLEZ: cond = z_eq | z_lt;
      OP_BGTZ: cond = z_gt;
      OP_BLTZ: cond = z_lt;
      OP_BGEZ: cond = ~z_lt;
      OP_J, OP_JAL: begin
        cond   = 1'b1;
        target = j_tgt;
      end
      OP_JR, OP_JALR: begin
        cond   = 1'b1;
        is_jr  = 1'b1;
        target = jr_tgt;
      end
`ifdef BRANCH_LIKELY_EN
      OP_BEQL: begin
        cond   = r_eq;
        likely = 1'b1;
      end
      OP_BNEL: begin
        cond   = ~r_eq;
        likely = 1'b1;
      end
`endif
      default: is_br = 1'b0;
    endcase
  end

  assign taken = resolve & is_br & cond;
  assign npc   = taken ? target : pc_f + 32'd4;

`ifdef BRANCH_LIKELY_EN
  assign flush_d = resolve & likely & ~cond;
`else
  assign flush_d = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_f         <= RESET_PC;
      br_cnt       <= '0;
      taken_cnt    <= '0;
      misalign_err <= 1'b0;
    end else if (!stall) begin
      pc_f <= npc;
      if (resolve && is_br) begin
        br_cnt <= br_cnt + CNT_W'(1);
        if (cond) taken_cnt <= taken_cnt + CNT_W'(1);
        // Target low bits are dropped for the fetch, but the fault is remembered.
        if (is_jr && jr_target[1:0] != 2'b00) misalign_err <= 1'b1;
      end
    end
  end
endmodule
